// File: rtl/hist_eq_sequencer.sv
// hist_eq_sequencer: three-pass histogram equalization over the source image.
// Builds a 256-bin histogram, folds it into a CDF-based remap LUT, then
// streams every pixel through the LUT into the destination image buffer.
//
// state  | meaning
// IDLE   | waiting for iStart
// CLR    | zeroing hist[0..255], one bin per cycle
// HIST   | reading pixels 0..N-1, counting each returned value one cycle later
// CDF    | accumulating hist into cdf and writing lut[v] = (cdf*255) >> ADDR_WIDTH
// MAP    | reading pixels again, writing lut[pixel] to destination one cycle later
// DONE   | one-cycle completion pulse
module hist_eq_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rClk,
  input  logic                  iRST_N,
  input  logic                  iStart,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oMemRe,
  output logic [ADDR_WIDTH-1:0] oMemRa,
  input  logic [DATA_WIDTH-1:0] iMemRd,
  output logic                  oMemWe,
  output logic [ADDR_WIDTH-1:0] oMemWa,
  output logic [DATA_WIDTH-1:0] oMemWd
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int MW = ADDR_WIDTH + 9;
  localparam logic [PW-1:0] NPIX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_HIST, S_CDF, S_MAP, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    bin;
  logic [PW-1:0] pix;
  logic [PW-1:0] cdf;
  logic [PW-1:0] cdf_nxt;
  logic [MW-1:0] prod;
  logic [7:0]    lut_val;

  logic [PW-1:0] hist [0:255];
  logic [7:0]    lut  [0:255];

  // CDF step: running sum and its scaled 8-bit remap value
  always_comb begin
    cdf_nxt = cdf + hist[bin];
    prod    = MW'(cdf_nxt) * MW'(255);
    lut_val = 8'(prod >> ADDR_WIDTH);
  end

  // State register
  always_ff @(posedge rClk or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (iStart)       state_nxt = S_CLR;
      S_CLR:  if (bin == 8'd255) state_nxt = S_HIST;
      S_HIST: if (pix == NPIX)   state_nxt = S_CDF;
      S_CDF:  if (bin == 8'd255) state_nxt = S_MAP;
      S_MAP:  if (pix == NPIX)   state_nxt = S_DONE;
      S_DONE:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Outputs: read port active for pix 0..N-1, write port lags it by one cycle
  always_comb begin
    oBusy  = (state != S_IDLE) && (state != S_DONE);
    oDone  = (state == S_DONE);
    oMemRe = ((state == S_HIST) || (state == S_MAP)) && (pix != NPIX);
    oMemRa = oMemRe ? pix[ADDR_WIDTH-1:0] : '0;
    oMemWe = (state == S_MAP) && (pix != '0);
    oMemWa = oMemWe ? ADDR_WIDTH'(pix - PW'(1)) : '0;
    oMemWd = oMemWe ? lut[iMemRd] : '0;
  end

  // Bin/pixel counters and CDF accumulator; bin wraps 255->0 between passes
  always_ff @(posedge rClk or negedge iRST_N) begin
    if (!iRST_N) begin
      bin <= '0;
      pix <= '0;
      cdf <= '0;
    end else begin
      case (state)
        S_CLR: begin
          bin <= bin + 8'd1;
          pix <= '0;
        end
        S_HIST: begin
          pix <= (pix == NPIX) ? '0 : pix + PW'(1);
          cdf <= '0;
        end
        S_CDF: begin
          bin <= bin + 8'd1;
          cdf <= cdf_nxt;
        end
        S_MAP: pix <= (pix == NPIX) ? '0 : pix + PW'(1);
        default: begin
          bin <= '0;
          pix <= '0;
        end
      endcase
    end
  end

  // Histogram storage: read-modify-write in the same cycle, so repeats never collide
  always_ff @(posedge rClk) begin
    if (state == S_CLR)
      hist[bin] <= '0;
    else if ((state == S_HIST) && (pix != '0))
      hist[iMemRd] <= hist[iMemRd] + PW'(1);
  end

  // Remap LUT written during the CDF pass
  always_ff @(posedge rClk) begin
    if (state == S_CDF) lut[bin] <= lut_val;
  end

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Self-checking bench for hist_eq_sequencer on a 32x32 image (N = 1024).
module tb_hist_eq_sequencer;

  localparam int AW = 10;
  localparam int N  = 1 << AW;
  localparam int L  = 2 * N + 515;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, re, we;
  logic [AW-1:0] ra, wa;
  logic [7:0]    rd, wd;

  hist_eq_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .rClk(clk), .iRST_N(rst_n), .iStart(start),
    .oBusy(busy), .oDone(done),
    .oMemRe(re), .oMemRa(ra), .iMemRd(rd),
    .oMemWe(we), .oMemWa(wa), .oMemWd(wd)
  );

  always #5 clk = ~clk;

  logic [7:0] img [N];
  logic [7:0] wr [N];
  logic [7:0] prev_wr [N];
  int         mlut [256];
  int         wcount;
  int         checks = 0;
  int         errors = 0;

  // Source memory: one-cycle read latency
  always @(posedge clk) rd <= re ? img[ra] : 8'h00;

  typedef struct {
    int kind;     // 0 const 0x40, 1 ramp, 2 half/half, 3 random, 4 keep image
    bit pulses;
    bit hold;
    bit armed;
    int a0; int e0;
    int a1; int e1;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_image(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: img[i] = 8'h40;
        1: img[i] = 8'(i);
        2: img[i] = (i < N / 2) ? 8'h00 : 8'hFF;
        3: img[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 103))
                                                 : 8'($urandom_range(0, 255));
        default: ;
      endcase
    end
  endtask

  // Reference: histogram -> cumulative count -> scaled LUT
  task automatic build_model();
    int h [256];
    int acc;
    foreach (h[v]) h[v] = 0;
    for (int i = 0; i < N; i++) h[img[i]]++;
    acc = 0;
    for (int v = 0; v < 256; v++) begin
      acc += h[v];
      mlut[v] = (acc * 255) >> AW;
    end
  endtask

  // One full run: cycle c counts from the first cycle after the iStart-sampling edge
  task automatic run(input bit armed, input bit pulses, input bit hold);
    int bad_ctl, bad_rd, bad_wr, done_at;
    bit e_re, e_we;
    int e_ra, e_wa, e_wd;
    bad_ctl = 0; bad_rd = 0; bad_wr = 0; done_at = -1; wcount = 0;
    build_model();
    @(negedge clk);
    if (armed) check("idle_between_runs", int'(busy) + int'(done), 0);
    else start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (pulses && (c == 400 || c == N + 700)) start = 1'b1;
      if (pulses && (c == 401 || c == N + 701)) start = 1'b0;
      e_re = (c >= 257 && c <= 256 + N) || (c >= N + 514 && c <= 2 * N + 513);
      e_ra = !e_re ? 0 : (c <= 256 + N) ? c - 257 : c - (N + 514);
      e_we = (c >= N + 515) && (c <= 2 * N + 514);
      e_wa = e_we ? c - (N + 515) : 0;
      e_wd = e_we ? mlut[img[e_wa]] : 0;
      if (busy !== (c < L) || done !== (c == L)) bad_ctl++;
      if (re !== e_re || int'(ra) !== e_ra) bad_rd++;
      if (we !== e_we || int'(wa) !== e_wa || int'(wd) !== e_wd) bad_wr++;
      if (we === 1'b1) begin
        if (wcount < N) wr[wcount] = wd;
        wcount++;
      end
      if (done === 1'b1 && done_at < 0) done_at = c;
    end
    check("busy_done_cycles_bad", bad_ctl, 0);
    check("read_port_cycles_bad", bad_rd, 0);
    check("write_port_cycles_bad", bad_wr, 0);
    check("write_count", wcount, N);
    check("done_latency", done_at, L);
  endtask

  initial begin
    int bad, diffs;
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 0,       255, N - 1, 255};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 0,       0,   127,   127};
    vecs[2] = '{4, 1'b0, 1'b0, 1'b0, 255,     255, N - 1, 255};
    vecs[3] = '{2, 1'b0, 1'b0, 1'b0, N/2 - 1, 127, N / 2, 255};
    vecs[4] = '{3, 1'b1, 1'b0, 1'b0, -1,      0,   -1,    0};
    vecs[5] = '{3, 1'b0, 1'b1, 1'b0, -1,      0,   -1,    0};
    vecs[6] = '{4, 1'b0, 1'b0, 1'b1, -1,      0,   -1,    0};

    #12;
    check("reset_outputs", int'({busy, done, re, we, ra, wa, wd}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'({busy, done, re, we}), 0);

    for (int t = 0; t < 7; t++) begin
      fill_image(vecs[t].kind);
      run(vecs[t].armed, vecs[t].pulses, vecs[t].hold);
      if (vecs[t].a0 >= 0) check($sformatf("vec%0d_wd_at_%0d", t, vecs[t].a0), int'(wr[vecs[t].a0]), vecs[t].e0);
      if (vecs[t].a1 >= 0) check($sformatf("vec%0d_wd_at_%0d", t, vecs[t].a1), int'(wr[vecs[t].a1]), vecs[t].e1);
      if (vecs[t].armed) begin
        diffs = 0;
        for (int i = 0; i < N; i++) if (wr[i] !== prev_wr[i]) diffs++;
        check("rerun_writes_differ", diffs, 0);
      end
      for (int i = 0; i < N; i++) prev_wr[i] = wr[i];
    end

    // Reset in mid-HIST at pixel 500
    fill_image(3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 257 + 500; c++) @(negedge clk);
    check("pre_reset_read_addr", re ? int'(ra) : -1, 500);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({busy, done, re, we, ra, wa, wd}), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || re !== 1'b0) bad++;
    end
    check("activity_after_abort", bad, 0);
    fill_image(3);
    run(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
